// File: rtl/cache_definition.sv
// Shared cache/memory interface types plus the main-memory responder defaults.
package cache_definition;

   typedef logic [127:0] cache_data_type;

   typedef struct packed {
      logic [19:0]    addr;
      cache_data_type data;
      logic           rw;
      logic           valid;
   } cache_to_mem_type;

   typedef struct packed {
      cache_data_type data;
      logic           ready;
   } mem_to_cache_type;

   localparam int unsigned MEM_LATENCY_DEFAULT  = 4;
   localparam int unsigned MEM_STORE_AW_DEFAULT = 10;

   typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_resp_state_type;

endpackage

// File: rtl/sa_mem_store.sv
// Single-port block store: synchronous write, synchronous read-first output.
module sa_mem_store
   import cache_definition::*;
#(
   parameter int unsigned AW        = MEM_STORE_AW_DEFAULT,
   parameter bit          ZERO_INIT = 1'b1
) (
   input  logic           i_clk,
   input  logic           i_we,
   input  logic [AW-1:0]  i_addr,
   input  cache_data_type i_wdata,
   output cache_data_type o_rdata
);

   cache_data_type r_rdata;

   // Power-up contents chosen by a declaration initialiser rather than a reset.
   if (ZERO_INIT) begin : g_zero
      cache_data_type r_mem [2**AW] = '{default: '0};

      always_ff @(posedge i_clk) begin
         if (i_we) r_mem[i_addr] <= i_wdata;
         r_rdata <= r_mem[i_addr];
      end
   end else begin : g_x
      cache_data_type r_mem [2**AW];

      always_ff @(posedge i_clk) begin
         if (i_we) r_mem[i_addr] <= i_wdata;
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sa_main_mem_responder.sv
// Memory end of the cache<->memory interface: one request at a time, fixed latency,
// single-cycle ready pulse with registered read data.
module sa_main_mem_responder
   import cache_definition::*;
#(
   parameter int unsigned LATENCY   = MEM_LATENCY_DEFAULT,
   parameter int unsigned STORE_AW  = MEM_STORE_AW_DEFAULT,
   parameter bit          ZERO_INIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  cache_to_mem_type cache_to_mem,
   output mem_to_cache_type mem_to_cache,
   output logic             busy,
   output logic [31:0]      rd_count,
   output logic [31:0]      wr_count
);

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   mem_resp_state_type  r_state;
   logic [7:0]          r_cnt;
   logic [STORE_AW-1:0] r_addr;
   logic                r_rw;
   cache_data_type      r_wdata;
   cache_data_type      r_rdata;
   logic                r_ready;
   logic                r_busy;
   logic [31:0]         r_rd_count;
   logic [31:0]         r_wr_count;

   logic                w_store_we;
   logic [STORE_AW-1:0] w_store_addr;
   cache_data_type      w_store_rdata;
   logic                w_unused_addr;

   // Store is addressed from the live request in IDLE so the synchronous read has
   // settled by the cnt==0 edge even when LATENCY is 1.
   always_comb begin
      w_store_we   = (r_state == MEM_WAIT) && (r_cnt == '0) && r_rw;
      w_store_addr = (r_state == MEM_IDLE) ? cache_to_mem.addr[STORE_AW-1:0] : r_addr;
   end

   assign w_unused_addr = ^cache_to_mem.addr[19:STORE_AW];

   sa_mem_store #(
      .AW        (STORE_AW),
      .ZERO_INIT (ZERO_INIT)
   ) u_store (
      .i_clk   (clk),
      .i_we    (w_store_we),
      .i_addr  (w_store_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_store_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= MEM_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_rw       <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         case (r_state)
            MEM_IDLE: begin
               r_ready <= 1'b0;
               if (cache_to_mem.valid) begin
                  r_addr  <= cache_to_mem.addr[STORE_AW-1:0];
                  r_rw    <= cache_to_mem.rw;
                  r_wdata <= cache_to_mem.data;
                  r_cnt   <= LAT_M1;
                  r_busy  <= 1'b1;
                  r_state <= MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               if (r_cnt == '0) begin
                  if (!r_rw) r_rdata <= w_store_rdata;
                  r_ready <= 1'b1;
                  r_state <= MEM_RESP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            MEM_RESP: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               if (r_rw) r_wr_count <= r_wr_count + 32'd1;
               else      r_rd_count <= r_rd_count + 32'd1;
               r_state <= MEM_IDLE;
            end
            default: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= MEM_IDLE;
            end
         endcase
      end
   end

   assign mem_to_cache.data  = r_rdata;
   assign mem_to_cache.ready = r_ready;
   assign busy               = r_busy;
   assign rd_count           = r_rd_count;
   assign wr_count           = r_wr_count;

endmodule

// File: tb/tb_sa_main_mem_responder.sv
// Directed bench for sa_main_mem_responder: vector table plus multi-cycle corner sequences.
module tb_sa_main_mem_responder;
   import cache_definition::*;

   localparam int unsigned LAT = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   cache_to_mem_type c2m;
   mem_to_cache_type m2c;
   logic             busy;
   logic [31:0]      rd_count;
   logic [31:0]      wr_count;

   int checks = 0;
   int errors = 0;

   sa_main_mem_responder #(
      .LATENCY   (LAT),
      .STORE_AW  (10),
      .ZERO_INIT (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cache_to_mem (c2m),
      .mem_to_cache (m2c),
      .busy         (busy),
      .rd_count     (rd_count),
      .wr_count     (wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [19:0] addr;
      logic [127:0] wdata;
      bit          scramble;
      logic [127:0] exp_data;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   vec_t vecs[8];

   localparam logic [127:0] D_BEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [127:0] D_X1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] D_X2   = 128'hA5A5_5A5A_0F0F_F0F0_CAFE_F00D_1234_5678;
   localparam logic [127:0] D_X3   = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
   localparam logic [127:0] D_A    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issues one request; returns with the bench at the negedge inside the ready cycle.
   task automatic do_req(input logic rw, input logic [19:0] addr, input logic [127:0] wd,
                         input bit scramble, output int lat, output logic bsy);
      lat = 0;
      @(negedge clk);
      c2m.addr  = addr;
      c2m.data  = wd;
      c2m.rw    = rw;
      c2m.valid = 1'b1;
      @(posedge clk);
      #1;
      c2m.valid = 1'b0;
      bsy = busy;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (m2c.ready) begin
            lat = i;
            c2m.valid = 1'b0;
            break;
         end
         if (scramble) begin
            c2m.addr  = 20'($urandom);
            c2m.rw    = 1'($urandom_range(0, 1));
            c2m.data  = {$urandom, $urandom, $urandom, $urandom};
            c2m.valid = 1'($urandom_range(0, 1));
         end
      end
   endtask

   initial begin
      int   lat;
      logic bsy;
      int   r1;
      int   r2;
      logic [127:0] got;

      vecs[0] = '{1'b1, 20'h00005, D_BEEF, 1'b0, 128'h0,  0, 1};
      vecs[1] = '{1'b0, 20'h00005, '0,     1'b1, D_BEEF,  1, 1};
      vecs[2] = '{1'b0, 20'h00405, '0,     1'b0, D_BEEF,  2, 1};
      vecs[3] = '{1'b1, 20'h003FF, D_X1,   1'b1, D_BEEF,  2, 2};
      vecs[4] = '{1'b0, 20'h003FF, '0,     1'b1, D_X1,    3, 2};
      vecs[5] = '{1'b0, 20'h00100, '0,     1'b0, 128'h0,  4, 2};
      vecs[6] = '{1'b1, 20'h00100, D_X2,   1'b0, 128'h0,  4, 3};
      vecs[7] = '{1'b0, 20'hFFD00, '0,     1'b0, D_X2,    5, 3};

      c2m = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 128'(m2c.ready), 128'h0);
      chk("rst_busy",  128'(busy),      128'h0);
      rst = 1'b1;

      // Idle after reset: nothing may move while valid stays low.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d_ready", i), 128'(m2c.ready), 128'h0);
         chk($sformatf("idle%0d_busy", i),  128'(busy),      128'h0);
         chk($sformatf("idle%0d_data", i),  m2c.data,        128'h0);
         chk($sformatf("idle%0d_rd", i),    128'(rd_count),  128'h0);
         chk($sformatf("idle%0d_wr", i),    128'(wr_count),  128'h0);
      end

      for (int i = 0; i < 8; i++) begin
         do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].scramble, lat, bsy);
         chk($sformatf("v%0d_latency", i), 128'(lat), 128'(LAT + 1));
         chk($sformatf("v%0d_busy", i),    128'(bsy), 128'h1);
         chk($sformatf("v%0d_data", i),    m2c.data,  vecs[i].exp_data);
         @(negedge clk);
         chk($sformatf("v%0d_ready_drop", i), 128'(m2c.ready), 128'h0);
         chk($sformatf("v%0d_busy_drop", i),  128'(busy),      128'h0);
         chk($sformatf("v%0d_rd", i), 128'(rd_count), 128'(vecs[i].exp_rd));
         chk($sformatf("v%0d_wr", i), 128'(wr_count), 128'(vecs[i].exp_wr));
      end

      // valid held high: write-back then allocate read of the same block.
      r1 = 0;
      r2 = 0;
      got = '0;
      @(negedge clk);
      c2m.addr  = 20'h00012;
      c2m.data  = D_A;
      c2m.rw    = 1'b1;
      c2m.valid = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (m2c.ready) begin
            if (r1 == 0) r1 = i;
            else begin
               r2 = i;
               got = m2c.data;
               c2m.valid = 1'b0;
               break;
            end
         end
         if (r1 != 0 && i == r1 + 1) begin
            c2m.rw   = 1'b0;
            c2m.data = '0;
         end
      end
      chk("b2b_first_seen", 128'(r1 != 0), 128'h1);
      chk("b2b_gap",        128'(r2 - r1), 128'(LAT + 2));
      chk("b2b_data",       got,           D_A);
      @(negedge clk);
      chk("b2b_rd", 128'(rd_count), 128'd6);
      chk("b2b_wr", 128'(wr_count), 128'd4);

      // Reset during WAIT of a write with cnt==2: the write must be lost.
      @(negedge clk);
      c2m.addr  = 20'h003FF;
      c2m.data  = D_X3;
      c2m.rw    = 1'b1;
      c2m.valid = 1'b1;
      @(posedge clk);
      #1;
      c2m.valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_ready", 128'(m2c.ready), 128'h0);
      chk("midrst_busy",  128'(busy),      128'h0);
      chk("midrst_wr",    128'(wr_count),  128'h0);
      chk("midrst_rd",    128'(rd_count),  128'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("postrst%0d_ready", i), 128'(m2c.ready), 128'h0);
         chk($sformatf("postrst%0d_wr", i),    128'(wr_count),  128'h0);
      end
      do_req(1'b0, 20'h003FF, '0, 1'b0, lat, bsy);
      chk("postrst_rd_latency", 128'(lat), 128'(LAT + 1));
      chk("postrst_rd_data",    m2c.data,  D_X1);
      @(negedge clk);
      chk("postrst_rd_count", 128'(rd_count), 128'h1);
      chk("postrst_wr_count", 128'(wr_count), 128'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
